// File: rtl/line_buffer3_pkg.sv
// Shared camera-pipeline constants and line-phase type for the 3-line buffer.
// Downstream 3x3 filter blocks import the same package.
package line_buffer3_pkg;

  localparam int LB_DATA_WIDTH = 10;
  localparam int LB_LINE_WIDTH = 640;
  localparam int LB_ADDR_WIDTH = $clog2(LB_LINE_WIDTH);

  // Number of completed lines since frame start, saturating at two.
  typedef enum logic [1:0] {
    LINE_FIRST  = 2'd0,
    LINE_SECOND = 2'd1,
    LINE_FULL   = 2'd2
  } line_phase_t;

  function automatic line_phase_t line_phase_next(input line_phase_t cur);
    line_phase_t nxt;
    nxt = cur;
    if (cur == LINE_FIRST) begin
      nxt = LINE_SECOND;
    end else if (cur == LINE_SECOND) begin
      nxt = LINE_FULL;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/line_buffer3_ram.sv
// Simple dual-port line memory: one write port, one read port with a
// registered (1-cycle) read. No reset on storage or read register.
module line_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Same-edge read and write to one address returns the old contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_buffer3.sv
// Three-line buffer: delays the current Bayer pixel by 2 clk and presents the
// same column from the two previous lines alongside it.
module line_buffer3
  import line_buffer3_pkg::*;
#(
  parameter int DATA_WIDTH = LB_DATA_WIDTH,
  parameter int LINE_WIDTH = LB_LINE_WIDTH,
  parameter int ADDR_WIDTH = LB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_i,
  input  logic                  de_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data0_o,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o
);

  // Stream semantics: one pixel is accepted on every cycle with de_i=1; there
  // is no ready path, so the block never stalls the source.
  localparam int HC_W = ADDR_WIDTH + 1;

  logic [HC_W-1:0]       r_hcount;
  line_phase_t           r_lcount;
  logic                  r_de_prev;

  logic                  r_vs1;
  logic                  r_de1;
  logic                  r_wr1;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [DATA_WIDTH-1:0] r_data1;
  line_phase_t           r_lc1;

  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_rd0;
  logic [DATA_WIDTH-1:0] w_rd1;

  // vsync blocks the write even when de_i is also high.
  assign w_wr   = de_i & ~vsync_i & (r_hcount < HC_W'(LINE_WIDTH));
  assign w_addr = r_hcount[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcount  <= '0;
      r_lcount  <= LINE_FIRST;
      r_de_prev <= 1'b0;
    end else if (vsync_i) begin
      r_hcount  <= '0;
      r_lcount  <= LINE_FIRST;
      r_de_prev <= 1'b0;
    end else begin
      r_de_prev <= de_i;
      if (!de_i) begin
        r_hcount <= '0;
      end else if (r_hcount < HC_W'(LINE_WIDTH)) begin
        r_hcount <= r_hcount + HC_W'(1);
      end
      if (r_de_prev && !de_i) begin
        r_lcount <= line_phase_next(r_lcount);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1   <= 1'b0;
      r_de1   <= 1'b0;
      r_wr1   <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
      r_lc1   <= LINE_FIRST;
    end else begin
      r_vs1   <= vsync_i;
      r_de1   <= de_i;
      r_wr1   <= w_wr;
      r_addr1 <= w_addr;
      r_data1 <= data_i;
      r_lc1   <= r_lcount;
    end
  end

  line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LINE_WIDTH)
  ) u_ram0 (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (w_addr),
    .i_wdata (data_i),
    .i_re    (w_wr),
    .i_raddr (w_addr),
    .o_rdata (w_rd0)
  );

  // Memory 1 is fed from memory 0's read port one cycle later: the cascade.
  line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LINE_WIDTH)
  ) u_ram1 (
    .clk     (clk),
    .i_we    (r_wr1),
    .i_waddr (r_addr1),
    .i_wdata (w_rd0),
    .i_re    (w_wr),
    .i_raddr (w_addr),
    .o_rdata (w_rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
      data0_o <= '0;
      data1_o <= '0;
      data2_o <= '0;
    end else begin
      vsync_o <= r_vs1;
      de_o    <= r_de1;
      if (r_de1) begin
        data2_o <= r_data1;
        data1_o <= (r_wr1 && (r_lc1 != LINE_FIRST)) ? w_rd0 : '0;
        data0_o <= (r_wr1 && (r_lc1 == LINE_FULL))  ? w_rd1 : '0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer3.sv
// Scoreboard bench for line_buffer3: a line-level reference model queues the
// expected {data0,data1,data2} per pixel; a monitor pops on every de_o cycle.
`timescale 1ns/1ps
module tb_line_buffer3;

  localparam int DW = 16;
  localparam int LW = 640;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vsync_i;
  logic          de_i;
  logic [DW-1:0] data_i;
  logic          vsync_o;
  logic          de_o;
  logic [DW-1:0] data0_o;
  logic [DW-1:0] data1_o;
  logic [DW-1:0] data2_o;

  line_buffer3 #(
    .DATA_WIDTH (DW),
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vsync_i),
    .de_i    (de_i),
    .data_i  (data_i),
    .vsync_o (vsync_o),
    .de_o    (de_o),
    .data0_o (data0_o),
    .data1_o (data1_o),
    .data2_o (data2_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [3*DW-1:0] exp_q[$];
  logic [3*DW-1:0] last_exp;
  int              total = 0;
  int              bad   = 0;

  logic [DW-1:0]   ref_l1 [LW];
  logic [DW-1:0]   ref_l2 [LW];
  int              m_col;
  int              m_lc;
  bit              m_prev;

  logic [3*DW-1:0] spot_exp;
  string           spot_name;
  event            spot_ev;

  logic [1:0]      h_de;
  logic [1:0]      h_vs;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step(input logic vs, input logic de, input logic [DW-1:0] d);
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    if (vs) begin
      if (de) exp_q.push_back({{DW{1'b0}}, {DW{1'b0}}, d});
      m_col  = 0;
      m_lc   = 0;
      m_prev = 1'b0;
    end else if (de) begin
      e0 = '0;
      e1 = '0;
      if (m_col < LW) begin
        if (m_lc >= 2) e0 = ref_l2[m_col];
        if (m_lc >= 1) e1 = ref_l1[m_col];
        ref_l2[m_col] = ref_l1[m_col];
        ref_l1[m_col] = d;
      end
      exp_q.push_back({e0, e1, d});
      m_col++;
      m_prev = 1'b1;
    end else begin
      if (m_prev && m_lc < 2) m_lc++;
      m_prev = 1'b0;
      m_col  = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic vs, input logic de, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    vsync_i = vs;
    de_i    = de;
    data_i  = d;
    model_step(vs, de, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0);
  endtask

  task automatic mid_reset_pixel(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    vsync_i = 1'b0;
    de_i    = 1'b1;
    data_i  = d;
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("async_rst_data0", data0_o, 0);
    chk("async_rst_data1", data1_o, 0);
    chk("async_rst_data2", data2_o, 0);
    chk("async_rst_de", de_o, 0);
    chk("async_rst_vsync", vsync_o, 0);
    exp_q.delete();
    last_exp = '0;
    m_col    = 0;
    m_lc     = 0;
    m_prev   = 1'b0;
    #0.5;
    rst_n = 1'b1;
    model_step(1'b0, 1'b1, d);
  endtask

  task automatic drive_line(input int len, input int base, input int rst_at,
                            input int sc, input logic [3*DW-1:0] sx, input string sn);
    logic [DW-1:0] d;
    for (int col = 0; col < len; col++) begin
      d = DW'(base + col);
      if (col == rst_at) begin
        mid_reset_pixel(d);
      end else begin
        cycle(1'b0, 1'b1, d);
      end
      if (col == sc) begin
        spot_exp  = sx;
        spot_name = sn;
        ->spot_ev;
      end
    end
    idle(10);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (de_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pixel: got %0h with empty queue", {data0_o, data1_o, data2_o});
        end else begin
          last_exp = exp_q.pop_front();
          chk("pixel", {data0_o, data1_o, data2_o}, last_exp);
        end
      end else begin
        chk("hold", {data0_o, data1_o, data2_o}, last_exp);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_de <= 2'b00;
      h_vs <= 2'b00;
    end else begin
      h_de <= {h_de[0], de_i};
      h_vs <= {h_vs[0], vsync_i};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("de_align", de_o, h_de[1]);
      chk("vsync_align", vsync_o, h_vs[1]);
    end
  end

  // Exact 2-clk latency: sampled at the next edge, visible after the one after.
  always @(spot_ev) begin
    repeat (2) @(posedge clk);
    #1;
    chk({spot_name, "_de"}, de_o, 1);
    chk(spot_name, {data0_o, data1_o, data2_o}, spot_exp);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    vsync_i = 1'b0;
    de_i    = 1'b0;
    data_i  = '0;
    last_exp = '0;
    m_col = 0;
    m_lc  = 0;
    m_prev = 1'b0;
    for (int i = 0; i < LW; i++) begin
      ref_l1[i] = '0;
      ref_l2[i] = '0;
    end
    #3;
    chk("reset_data0", data0_o, 0);
    chk("reset_data1", data1_o, 0);
    chk("reset_data2", data2_o, 0);
    chk("reset_de", de_o, 0);
    chk("reset_vsync", vsync_o, 0);
    #10;
    rst_n = 1'b1;
    idle(3);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    idle(5);

    // Ramp frame
    drive_line(640, 0,    -1, -1, '0, "none");
    drive_line(640, 1000, -1, 7, {16'd0, 16'd7, 16'd1007}, "line1_col7");
    drive_line(640, 2000, -1, 5, {16'd5, 16'd1005, 16'd2005}, "line2_col5");

    // Overlong line, then an intact full line
    drive_line(700, 3000, -1, 650, {16'd0, 16'd0, 16'd3650}, "overlong_col650");
    drive_line(640, 4000, -1, 639, {16'd2639, 16'd3639, 16'd4639}, "after_overlong_col639");

    // Short line leaves the tail untouched
    drive_line(100, 5000, -1, -1, '0, "none");
    drive_line(640, 6000, -1, 300, {16'd3300, 16'd4300, 16'd6300}, "short_tail_col300");

    // vsync and de together
    cycle(1'b1, 1'b1, 16'h7777);
    idle(10);
    drive_line(640, 7000, -1, 3, {16'd0, 16'd0, 16'd7003}, "after_collision_col3");
    drive_line(640, 8000, -1, 3, {16'd0, 16'd7003, 16'd8003}, "collision_line1_col3");

    // Alignment across 15 short lines with 10-cycle blanking
    for (int ln = 0; ln < 15; ln++) begin
      drive_line(20, 9000 + ln * 50, -1, -1, '0, "none");
    end

    // Reset mid-line: the remainder is line 0
    drive_line(40, 20000, 15, -1, '0, "none");
    drive_line(40, 21000, -1, 2, {16'd0, 16'd20017, 16'd21002}, "post_reset_line1_col2");
    drive_line(40, 22000, -1, 2, {16'd20017, 16'd21002, 16'd22002}, "post_reset_line2_col2");

    idle(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
